// File: rtl/ext_cpu_ctrl_slave.sv
// ---------------------------------------------------------------------------
// ext_cpu_ctrl_slave
//
// Bus responder that lets software restart individual harts of the external
// CPU cluster and choose the address each hart boots from afterwards.
//
// Each hart has its own restart sequencer. It waits for the hart to go to
// sleep (or gives up after a timeout), holds the hart's reset low for a
// programmable number of cycles, then releases it. The boot select is latched
// when reset goes low, so it is stable whenever the core can sample it.
//
// Register map (word address = addr[4:2]):
//   0x00 CTRL       W: bit h = 1 restarts hart h   R: busy bits
//   0x04 BOOT_SEL   RW [NHARTS-1:0]
//   0x08 STATUS     RO [NHARTS-1:0] sleep, [8+NHARTS-1:8] busy
//   0x0C RST_CYCLES RW [7:0], 0 behaves as 1
//   0x10 SCRATCH    RW [31:0]
//   0x14..0x1C      read 0, writes ignored
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   slave_req_i          request valid (always granted in the same cycle)
//   slave_we_i           1 = write, 0 = read
//   slave_be_i           byte enables for writes
//   slave_addr_i         byte address (only bits [4:2] decoded)
//   slave_wdata_i        write data
//   slave_gnt_o          grant, combinational copy of slave_req_i
//   slave_rvalid_o       response valid, one cycle after each grant
//   slave_rdata_o        registered read data, 0 for writes
//   sleep_i              per-hart sleep status from the cluster
//   reset_core_o         per-hart reset enable, 0 holds the core in reset
//   select_boot_addr_o   per-hart boot select, 0 = base, 1 = WFI address
//   busy_o               per-hart sequencer active
// ---------------------------------------------------------------------------
module ext_cpu_ctrl_slave #(
    parameter int NHARTS        = 3,
    parameter int RESET_CYCLES  = 8,
    parameter int SLEEP_TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              slave_req_i,
    input  logic              slave_we_i,
    input  logic [3:0]        slave_be_i,
    input  logic [31:0]       slave_addr_i,
    input  logic [31:0]       slave_wdata_i,
    output logic              slave_gnt_o,
    output logic              slave_rvalid_o,
    output logic [31:0]       slave_rdata_o,
    input  logic [NHARTS-1:0] sleep_i,
    output logic [NHARTS-1:0] reset_core_o,
    output logic [NHARTS-1:0] select_boot_addr_o,
    output logic [NHARTS-1:0] busy_o
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_SLEEP = 2'd1;
    localparam logic [1:0] ST_ASSERT_RST = 2'd2;
    localparam logic [1:0] ST_RELEASE    = 2'd3;

    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_BOOT_SEL   = 3'd1;
    localparam logic [2:0] REG_STATUS     = 3'd2;
    localparam logic [2:0] REG_RST_CYCLES = 3'd3;
    localparam logic [2:0] REG_SCRATCH    = 3'd4;

    // The timeout counter only has to reach SLEEP_TIMEOUT-1.
    localparam int              TO_W    = (SLEEP_TIMEOUT > 1) ? $clog2(SLEEP_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SLEEP_TIMEOUT - 1);

    // Bus response state
    logic                          rvalid_q, rvalid_d;
    logic [31:0]                   rdata_q, rdata_d;

    // Software-visible registers
    logic [NHARTS-1:0]             boot_sel_q, boot_sel_d;
    logic [7:0]                    rst_cycles_q, rst_cycles_d;
    logic [31:0]                   scratch_q, scratch_d;

    // Per-hart sequencer state
    logic [NHARTS-1:0][1:0]        state_q, state_d;
    logic [NHARTS-1:0][TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [NHARTS-1:0][7:0]        rst_cnt_q, rst_cnt_d;
    logic [NHARTS-1:0]             sel_q, sel_d;
    logic [NHARTS-1:0]             reset_core_q, reset_core_d;

    logic [2:0]                    reg_idx;
    logic                          wr_en;
    logic [NHARTS-1:0]             busy;
    logic [NHARTS-1:0]             restart_req;
    logic [31:0]                   rd_val;
    logic [7:0]                    rst_load;
    logic                          unused_addr_bits;

    assign reg_idx          = slave_addr_i[4:2];
    assign wr_en            = slave_req_i & slave_we_i;
    assign unused_addr_bits = ^{slave_addr_i[31:5], slave_addr_i[1:0]};

    // No backpressure: every request is accepted in the cycle it appears.
    assign slave_gnt_o    = slave_req_i;
    assign slave_rvalid_o = rvalid_q;
    assign slave_rdata_o  = rdata_q;

    assign reset_core_o       = reset_core_q;
    assign select_boot_addr_o = sel_q;
    assign busy_o             = busy;

    // A programmed length of zero would otherwise skip the reset pulse.
    assign rst_load = (rst_cycles_q == 8'd0) ? 8'd1 : rst_cycles_q;

    // Busy flags straight from the sequencer states.
    always_comb begin
        busy = '0;
        for (int h = 0; h < NHARTS; h++) begin
            busy[h] = (state_q[h] != ST_IDLE);
        end
    end

    // Read mux. Values reflect the state in the request cycle; the response
    // appears one cycle later through the rdata register.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_CTRL:       rd_val[NHARTS-1:0] = busy;
            REG_BOOT_SEL:   rd_val[NHARTS-1:0] = boot_sel_q;
            REG_STATUS: begin
                rd_val[NHARTS-1:0]  = sleep_i;
                rd_val[8 +: NHARTS] = busy;
            end
            REG_RST_CYCLES: rd_val[7:0] = rst_cycles_q;
            REG_SCRATCH:    rd_val = scratch_q;
            default:        rd_val = '0;
        endcase
    end

    // Response channel: one rvalid per granted request, rdata zero on writes.
    always_comb begin
        rvalid_d = slave_req_i;
        rdata_d  = (slave_req_i && !slave_we_i) ? rd_val : 32'd0;
    end

    // Register writes, honouring byte enables. The hart-sized fields all live
    // in byte 0, so only be[0] gates them.
    always_comb begin
        boot_sel_d   = boot_sel_q;
        rst_cycles_d = rst_cycles_q;
        scratch_d    = scratch_q;
        restart_req  = '0;
        if (wr_en && slave_be_i[0]) begin
            case (reg_idx)
                REG_CTRL:       restart_req  = slave_wdata_i[NHARTS-1:0];
                REG_BOOT_SEL:   boot_sel_d   = slave_wdata_i[NHARTS-1:0];
                REG_RST_CYCLES: rst_cycles_d = slave_wdata_i[7:0];
                default:        ;
            endcase
        end
        if (wr_en && (reg_idx == REG_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (slave_be_i[b]) begin
                    scratch_d[b*8 +: 8] = slave_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Restart sequencers. Requests are only accepted in IDLE, so a restart
    // already in flight is never extended or re-queued. Boot select and reset
    // length are captured on entry to ASSERT_RST, so later register writes do
    // not disturb a running sequence. Because reset goes low one cycle after
    // the request at the earliest, a hart restarting itself still receives
    // its bus response first.
    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        rst_cnt_d    = rst_cnt_q;
        sel_d        = sel_q;
        reset_core_d = reset_core_q;
        for (int h = 0; h < NHARTS; h++) begin
            case (state_q[h])
                ST_IDLE: begin
                    reset_core_d[h] = 1'b1;
                    if (restart_req[h]) begin
                        state_d[h]  = ST_WAIT_SLEEP;
                        to_cnt_d[h] = '0;
                    end
                end
                ST_WAIT_SLEEP: begin
                    if (sleep_i[h] || (to_cnt_q[h] == TO_LAST)) begin
                        state_d[h]      = ST_ASSERT_RST;
                        sel_d[h]        = boot_sel_q[h];
                        rst_cnt_d[h]    = rst_load;
                        reset_core_d[h] = 1'b0;
                    end else begin
                        to_cnt_d[h] = to_cnt_q[h] + TO_W'(1);
                    end
                end
                ST_ASSERT_RST: begin
                    if (rst_cnt_q[h] <= 8'd1) begin
                        state_d[h]      = ST_RELEASE;
                        reset_core_d[h] = 1'b1;
                    end else begin
                        rst_cnt_d[h] = rst_cnt_q[h] - 8'd1;
                    end
                end
                default: begin
                    state_d[h]      = ST_IDLE;
                    reset_core_d[h] = 1'b1;
                end
            endcase
        end
    end

    // State registers. Reset drops any pending response and releases all
    // cores immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            boot_sel_q   <= '0;
            rst_cycles_q <= 8'(RESET_CYCLES);
            scratch_q    <= '0;
            state_q      <= '0;
            to_cnt_q     <= '0;
            rst_cnt_q    <= '0;
            sel_q        <= '0;
            reset_core_q <= '1;
        end else begin
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            boot_sel_q   <= boot_sel_d;
            rst_cycles_q <= rst_cycles_d;
            scratch_q    <= scratch_d;
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            sel_q        <= sel_d;
            reset_core_q <= reset_core_d;
        end
    end

endmodule

// File: tb/tb_ext_cpu_ctrl_slave.sv
// ---------------------------------------------------------------------------
// tb_ext_cpu_ctrl_slave
//
// Drives ext_cpu_ctrl_slave with directed and random bus traffic and sleep
// patterns. A timeline model tracks, per hart, the edge a restart was
// accepted and the edge its reset pulse started, and derives every output
// from those times.
// ---------------------------------------------------------------------------
module tb_ext_cpu_ctrl_slave;

    localparam int NH = 3;
    localparam int RC = 8;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rstN;
    logic          busReq;
    logic          busWe;
    logic [3:0]    busBe;
    logic [31:0]   busAddr;
    logic [31:0]   busWdata;
    logic          busGnt;
    logic          busRvalid;
    logic [31:0]   busRdata;
    logic [NH-1:0] sleepIn;
    logic [NH-1:0] resetCore;
    logic [NH-1:0] bootSel;
    logic [NH-1:0] busy;

    // Free-running clock
    always #5 clk = ~clk;

    ext_cpu_ctrl_slave #(
        .NHARTS        (NH),
        .RESET_CYCLES  (RC),
        .SLEEP_TIMEOUT (TO)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rstN),
        .slave_req_i        (busReq),
        .slave_we_i         (busWe),
        .slave_be_i         (busBe),
        .slave_addr_i       (busAddr),
        .slave_wdata_i      (busWdata),
        .slave_gnt_o        (busGnt),
        .slave_rvalid_o     (busRvalid),
        .slave_rdata_o      (busRdata),
        .sleep_i            (sleepIn),
        .reset_core_o       (resetCore),
        .select_boot_addr_o (bootSel),
        .busy_o             (busy)
    );

    int checkCount = 0;
    int errorCount = 0;
    int edgeNum    = 0;

    // Reference model state
    logic          mActive   [NH];
    int            mReqEdge  [NH];
    int            mRstStart [NH];
    int            mRstLen   [NH];
    logic [NH-1:0] mSel;
    logic [NH-1:0] mBootSel;
    logic [7:0]    mRstCycles;
    logic [31:0]   mScratch;
    logic          mRvalid;
    logic [31:0]   mRdata;

    // Per-hart observation counters for the directed tests
    int            busyCycles [NH];
    int            lowCycles  [NH];
    int            pulseCount [NH];
    logic [NH-1:0] prevReset;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one set of bus inputs
    task automatic applyStimulus(input logic req, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        busReq   = req;
        busWe    = we;
        busBe    = be;
        busAddr  = addr;
        busWdata = wdata;
    endtask

    task automatic modelReset();
        for (int h = 0; h < NH; h++) begin
            mActive[h]   = 1'b0;
            mReqEdge[h]  = 0;
            mRstStart[h] = -1;
            mRstLen[h]   = 0;
        end
        mSel       = '0;
        mBootSel   = '0;
        mRstCycles = 8'(RC);
        mScratch   = '0;
        mRvalid    = 1'b0;
        mRdata     = '0;
    endtask

    task automatic clearCounters();
        for (int h = 0; h < NH; h++) begin
            busyCycles[h] = 0;
            lowCycles[h]  = 0;
            pulseCount[h] = 0;
        end
        prevReset = resetCore;
    endtask

    // Advance the model by one clock edge using the inputs sampled there
    task automatic modelEdge();
        logic [2:0]    word;
        logic [31:0]   readVal;
        logic [NH-1:0] busyBefore;
        word = busAddr[4:2];
        for (int h = 0; h < NH; h++) busyBefore[h] = mActive[h];
        case (word)
            3'd0:    readVal = 32'(busyBefore);
            3'd1:    readVal = 32'(mBootSel);
            3'd2:    readVal = 32'(sleepIn) | (32'(busyBefore) << 8);
            3'd3:    readVal = 32'(mRstCycles);
            3'd4:    readVal = mScratch;
            default: readVal = 32'd0;
        endcase
        mRvalid = busReq;
        mRdata  = (busReq && !busWe) ? readVal : 32'd0;

        for (int h = 0; h < NH; h++) begin
            if (mActive[h]) begin
                if (mRstStart[h] >= 0) begin
                    // one release cycle after the reset pulse, then idle
                    if (edgeNum == mRstStart[h] + mRstLen[h] + 1) mActive[h] = 1'b0;
                end else if (sleepIn[h] || (edgeNum - mReqEdge[h]) == TO) begin
                    mRstStart[h] = edgeNum;
                    mRstLen[h]   = (mRstCycles == 8'd0) ? 1 : int'(mRstCycles);
                    mSel[h]      = mBootSel[h];
                end
            end else if (busReq && busWe && word == 3'd0 && busBe[0] && busWdata[h]) begin
                mActive[h]   = 1'b1;
                mReqEdge[h]  = edgeNum;
                mRstStart[h] = -1;
            end
        end

        if (busReq && busWe) begin
            if (busBe[0] && word == 3'd1) mBootSel = busWdata[NH-1:0];
            if (busBe[0] && word == 3'd3) mRstCycles = busWdata[7:0];
            if (word == 3'd4) begin
                for (int b = 0; b < 4; b++)
                    if (busBe[b]) mScratch[b*8 +: 8] = busWdata[b*8 +: 8];
            end
        end
    endtask

    // One clock cycle: check grant, clock, update model, check all outputs
    task automatic step();
        logic [NH-1:0] expBusy;
        logic [NH-1:0] expReset;
        #1;
        checkOutput("gnt", 32'(busGnt), 32'(busReq));
        @(posedge clk);
        edgeNum++;
        modelEdge();
        #1;
        for (int h = 0; h < NH; h++) begin
            expBusy[h]  = mActive[h];
            expReset[h] = !(mActive[h] && mRstStart[h] >= 0 &&
                            edgeNum < mRstStart[h] + mRstLen[h]);
        end
        checkOutput("busy", 32'(busy), 32'(expBusy));
        checkOutput("resetCore", 32'(resetCore), 32'(expReset));
        checkOutput("bootSel", 32'(bootSel), 32'(mSel));
        checkOutput("rvalid", 32'(busRvalid), 32'(mRvalid));
        checkOutput("rdata", busRdata, mRdata);
        for (int h = 0; h < NH; h++) begin
            if (busy[h]) busyCycles[h]++;
            if (!resetCore[h]) lowCycles[h]++;
            if (prevReset[h] && !resetCore[h]) pulseCount[h]++;
        end
        prevReset = resetCore;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        applyStimulus(1'b1, 1'b1, be, addr, data);
        step();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    endtask

    task automatic readExpect(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b0, 4'hF, addr, 32'd0);
        step();
        checkOutput(tag, busRdata, expected);
        checkOutput("readRvalid", 32'(busRvalid), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    endtask

    initial begin
        rstN    = 1'b0;
        sleepIn = '0;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        rstN = 1'b1;

        // Reset state
        checkOutput("rstResetCore", 32'(resetCore), 32'h7);
        checkOutput("rstBusy", 32'(busy), 32'h0);
        checkOutput("rstBootSel", 32'(bootSel), 32'h0);
        checkOutput("rstRvalid", 32'(busRvalid), 32'h0);
        checkOutput("rstRdata", busRdata, 32'h0);

        // Register reads after reset
        readExpect("readRstCycles", 32'h0C, 32'd8);
        step();
        checkOutput("rvalidOneCycle", 32'(busRvalid), 32'd0);
        sleepIn = 3'b010;
        readExpect("readStatus", 32'h08, 32'h002);

        // Restart hart 0 with sleep already high
        sleepIn = 3'b001;
        busWrite(32'h04, 32'h5, 4'hF);
        clearCounters();
        busWrite(32'h00, 32'h1, 4'hF);
        repeat (15) step();
        checkOutput("h0Low", 32'(lowCycles[0]), 32'd8);
        checkOutput("h0Busy", 32'(busyCycles[0]), 32'd10);
        checkOutput("h0Sel", 32'(bootSel[0]), 32'd1);
        checkOutput("h1Idle", 32'(busyCycles[1]), 32'd0);

        // Restart hart 1 that never sleeps: timeout path
        sleepIn = 3'b000;
        clearCounters();
        busWrite(32'h00, 32'h2, 4'hF);
        repeat (1040) step();
        checkOutput("h1TimeoutBusy", 32'(busyCycles[1]), 32'(TO + 8 + 1));
        checkOutput("h1TimeoutLow", 32'(lowCycles[1]), 32'd8);
        checkOutput("h1Sel", 32'(bootSel[1]), 32'd0);

        // Zero reset length, repeated request while busy
        sleepIn = 3'b100;
        busWrite(32'h0C, 32'h0, 4'hF);
        clearCounters();
        busWrite(32'h00, 32'h4, 4'hF);
        busWrite(32'h00, 32'h4, 4'hF);
        repeat (10) step();
        checkOutput("h2Low", 32'(lowCycles[2]), 32'd1);
        checkOutput("h2Pulses", 32'(pulseCount[2]), 32'd1);
        checkOutput("h2Busy", 32'(busyCycles[2]), 32'd3);
        checkOutput("h2Sel", 32'(bootSel[2]), 32'd1);

        // Scratch with byte enables, then back-to-back reads
        busWrite(32'h10, 32'hAABBCCDD, 4'hF);
        busWrite(32'h10, 32'h00001100, 4'b0010);
        readExpect("scratchBe", 32'h10, 32'hAABB11DD);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h10, 32'd0);
        step();
        checkOutput("b2bRvalid0", 32'(busRvalid), 32'd1);
        checkOutput("b2bRdata0", busRdata, 32'hAABB11DD);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h0C, 32'd0);
        step();
        checkOutput("b2bRvalid1", 32'(busRvalid), 32'd1);
        checkOutput("b2bRdata1", busRdata, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        step();
        checkOutput("b2bIdle", 32'(busRvalid), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0] word;
            logic       we;
            logic [31:0] data;
            word = 3'($urandom_range(0, 7));
            we   = 1'($urandom_range(0, 1));
            data = $urandom;
            if (word == 3'd3) data = 32'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0)
                applyStimulus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
            else
                applyStimulus(1'b1, we, 4'($urandom_range(0, 15)),
                              {27'($urandom), word, 2'($urandom)}, data);
            if ($urandom_range(0, 7) == 0) sleepIn = 3'($urandom_range(0, 7));
            step();
        end
        applyStimulus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        sleepIn = 3'b111;
        repeat (20) step();

        // Reset in the middle of hart 0's reset pulse, with a response pending
        sleepIn = 3'b001;
        busWrite(32'h0C, 32'd8, 4'hF);
        busWrite(32'h00, 32'h1, 4'hF);
        step();
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h10, 32'd0);
        step();
        checkOutput("preRstLow", 32'(resetCore[0]), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("asyncResetCore", 32'(resetCore), 32'h7);
        checkOutput("asyncBusy", 32'(busy), 32'h0);
        checkOutput("asyncRvalid", 32'(busRvalid), 32'h0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rstN = 1'b1;

        // Normal restart after reset
        clearCounters();
        busWrite(32'h00, 32'h1, 4'hF);
        repeat (15) step();
        checkOutput("postRstLow", 32'(lowCycles[0]), 32'd8);
        checkOutput("postRstBusy", 32'(busyCycles[0]), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
